tjmono2_fifo_merge: RTL and testbench

Round-robin merger placed directly downstream of one or more `tjmono2_rx` receivers. It pops 32-bit words from up to four first-word-fall-through receiver FIFO ports and forwards them, one word per clock in bursts, to a single valid/ready output stream feeding the readout FIFO/SiTCP path. Channels are individually maskable, and a per-grant burst limit bounds the latency seen by the other channels.

---
 rtl/tjmono2_fifo_merge_if.sv | 26 ++
 rtl/tjmono2_fifo_merge.sv | 124 ++++++++++++
 tb/tb_tjmono2_fifo_merge.sv | 261 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/tjmono2_fifo_merge_if.sv
// Bundle of receiver-FIFO pop ports and the merged valid/ready output stream
// for tjmono2_fifo_merge; the slave modport is the merger, the master is its environment.
interface tjmono2_fifo_merge_if #(
  parameter int unsigned N_CH = 2
);
  logic [N_CH-1:0]    ch_enable;
  logic [N_CH-1:0]    fifo_empty;
  logic [32*N_CH-1:0] fifo_data;
  logic [N_CH-1:0]    fifo_read;
  logic [31:0]        out_data;
  logic [1:0]         out_ch;
  logic               out_valid;
  logic               out_ready;
  logic               busy;
  logic [31:0]        word_cnt;

  modport master (
    output ch_enable, fifo_empty, fifo_data, out_ready,
    input  fifo_read, out_data, out_ch, out_valid, busy, word_cnt
  );

  modport slave (
    input  ch_enable, fifo_empty, fifo_data, out_ready,
    output fifo_read, out_data, out_ch, out_valid, busy, word_cnt
  );
endinterface

// File: rtl/tjmono2_fifo_merge.sv
// Round-robin merger of up to four FWFT receiver FIFOs into one valid/ready stream,
// with per-channel masking and a per-grant burst limit.
module tjmono2_fifo_merge #(
  parameter int unsigned N_CH      = 2,
  parameter int unsigned MAX_BURST = 16
) (
  input logic                 i_clk,
  input logic                 i_rst_n,
  tjmono2_fifo_merge_if.slave bus
);
  typedef enum logic [0:0] {StArb, StXfer} state_e;

  localparam logic [7:0] MaxBurst = 8'(MAX_BURST);
  localparam logic [1:0] LastCh   = 2'(N_CH - 1);

  state_e      r_state, w_state_d;
  logic [1:0]  r_grant, w_grant_d;
  logic [7:0]  r_bcnt, w_bcnt_d;
  logic [31:0] r_out_data;
  logic [1:0]  r_out_ch;
  logic        r_out_valid;
  logic [31:0] r_word_cnt;

  logic [3:0]  w_en, w_empty;
  logic [31:0] w_data [4];
  logic        w_found;
  logic [1:0]  w_found_ch;
  logic        w_pop, w_accept;

  // Widen channel vectors to four entries so a 2-bit grant always indexes in range.
  always_comb begin
    w_en    = '0;
    w_empty = '1;
    for (int i = 0; i < 4; i++) w_data[i] = '0;
    for (int i = 0; i < int'(N_CH); i++) begin
      w_en[i]    = bus.ch_enable[i];
      w_empty[i] = bus.fifo_empty[i];
      w_data[i]  = bus.fifo_data[32*i +: 32];
    end
  end

  // Search grant+1, grant+2, ... ending with grant itself.
  always_comb begin
    logic [1:0] idx;
    w_found    = 1'b0;
    w_found_ch = r_grant;
    idx        = '0;
    for (int k = 1; k <= int'(N_CH); k++) begin
      idx = 2'((int'(r_grant) + k) % int'(N_CH));
      if (!w_found && w_en[idx] && !w_empty[idx]) begin
        w_found    = 1'b1;
        w_found_ch = idx;
      end
    end
  end

  assign w_pop = (r_state == StXfer) && w_en[r_grant] && !w_empty[r_grant] &&
                 (r_bcnt < MaxBurst) && (!r_out_valid || bus.out_ready);
  assign w_accept = r_out_valid && bus.out_ready;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= StArb;
      r_grant <= LastCh;
      r_bcnt  <= '0;
    end else begin
      r_state <= w_state_d;
      r_grant <= w_grant_d;
      r_bcnt  <= w_bcnt_d;
    end
  end

  always_comb begin
    w_state_d = r_state;
    w_grant_d = r_grant;
    w_bcnt_d  = r_bcnt;
    unique case (r_state)
      StArb: begin
        if (w_found) begin
          w_state_d = StXfer;
          w_grant_d = w_found_ch;
          w_bcnt_d  = '0;
        end
      end
      StXfer: begin
        if (w_pop) w_bcnt_d = r_bcnt + 8'd1;
        // Back-pressure alone never ends a grant.
        if (!w_en[r_grant] || w_empty[r_grant] || (w_bcnt_d >= MaxBurst)) w_state_d = StArb;
      end
      default: w_state_d = StArb;
    endcase
  end

  always_comb begin
    bus.fifo_read = '0;
    for (int i = 0; i < int'(N_CH); i++) begin
      bus.fifo_read[i] = w_pop && (r_grant == 2'(i));
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_out_data  <= '0;
      r_out_ch    <= '0;
      r_out_valid <= 1'b0;
      r_word_cnt  <= '0;
    end else begin
      if (w_pop) begin
        r_out_data  <= w_data[r_grant];
        r_out_ch    <= r_grant;
        r_out_valid <= 1'b1;
      end else if (w_accept) begin
        r_out_valid <= 1'b0;
      end
      if (w_accept) r_word_cnt <= r_word_cnt + 32'd1;
    end
  end

  assign bus.out_data  = r_out_data;
  assign bus.out_ch    = r_out_ch;
  assign bus.out_valid = r_out_valid;
  assign bus.busy      = (r_state == StXfer) || r_out_valid;
  assign bus.word_cnt  = r_word_cnt;
endmodule

// File: tb/tb_tjmono2_fifo_merge.sv
// Directed bench for tjmono2_fifo_merge: FWFT FIFO models per channel and an
// ordered scoreboard of hand-derived {channel, word} expectations.
module tb_tjmono2_fifo_merge;
  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  tjmono2_fifo_merge_if #(.N_CH(2)) bus ();

  tjmono2_fifo_merge #(
    .N_CH      (2),
    .MAX_BURST (16)
  ) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  logic [31:0] fq0[$];
  logic [31:0] fq1[$];
  logic [33:0] exp_q[$];

  int          cyc = 0;
  int          pops0, pops1;
  int          first_acc, last_acc;
  logic [1:0]  last_ch;
  bit          have_acc;
  int          gaps[$];
  bit          prev_v, prev_r;
  logic [31:0] prev_d;
  logic [1:0]  prev_c;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic refresh();
    bus.fifo_empty = {fq1.size() == 0, fq0.size() == 0};
    bus.fifo_data  = {(fq1.size() != 0) ? fq1[0] : 32'h0, (fq0.size() != 0) ? fq0[0] : 32'h0};
  endtask

  task automatic load(input int ch, input logic [31:0] base, input int n);
    for (int i = 0; i < n; i++) begin
      if (ch == 0) fq0.push_back(base + 32'(i));
      else         fq1.push_back(base + 32'(i));
    end
    refresh();
  endtask

  task automatic expect_seq(input int ch, input logic [31:0] base, input int start, input int n);
    for (int i = start; i < start + n; i++) exp_q.push_back({2'(ch), base + 32'(i)});
  endtask

  task automatic start_phase();
    gaps.delete();
    have_acc  = 1'b0;
    pops0     = 0;
    pops1     = 0;
    first_acc = -1;
    last_acc  = -1;
  endtask

  // Called just after a negedge; samples 1 time unit before the posedge.
  task automatic tick();
    logic [1:0]  rd;
    logic        v, r;
    logic [31:0] d;
    logic [1:0]  c;
    logic [33:0] e;
    #4;
    rd = bus.fifo_read;
    v  = bus.out_valid;
    r  = bus.out_ready;
    d  = bus.out_data;
    c  = bus.out_ch;
    if (rd != 2'b00) begin
      check_eq("pop_legal", 32'(!v || r), 32'd1);
      check_eq("pop_onehot", 32'($countones(rd)), 32'd1);
      if (rd[0]) begin
        check_eq("pop_en0", 32'(bus.ch_enable[0]), 32'd1);
        check_eq("pop_nonempty0", 32'(fq0.size() != 0), 32'd1);
        pops0++;
      end
      if (rd[1]) begin
        check_eq("pop_en1", 32'(bus.ch_enable[1]), 32'd1);
        check_eq("pop_nonempty1", 32'(fq1.size() != 0), 32'd1);
        pops1++;
      end
    end
    if (prev_v && !prev_r) begin
      check_eq("hold_valid", 32'(v), 32'd1);
      check_eq("hold_data", d, prev_d);
      check_eq("hold_ch", 32'(c), 32'(prev_c));
    end
    prev_v = v;
    prev_r = r;
    prev_d = d;
    prev_c = c;
    if (v && r) begin
      if (exp_q.size() == 0) begin
        check_eq("extra_word", 32'(exp_q.size()), 32'd1);
      end else begin
        e = exp_q.pop_front();
        check_eq("out_data", d, e[31:0]);
        check_eq("out_ch", 32'(c), 32'(e[33:32]));
      end
      if (have_acc && (c != last_ch)) gaps.push_back(cyc - last_acc);
      if (first_acc < 0) first_acc = cyc;
      have_acc = 1'b1;
      last_acc = cyc;
      last_ch  = c;
    end
    @(posedge clk);
    #1;
    if (rd[0] && fq0.size() != 0) void'(fq0.pop_front());
    if (rd[1] && fq1.size() != 0) void'(fq1.pop_front());
    refresh();
    cyc++;
    @(negedge clk);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    rst_n          = 1'b1;
    bus.ch_enable  = 2'b11;
    bus.out_ready  = 1'b1;
    refresh();
    prev_v = 1'b0;
    prev_r = 1'b0;
    prev_d = '0;
    prev_c = '0;
    start_phase();
    #1 rst_n = 1'b0;
    #1;
    check_eq("rst_valid", 32'(bus.out_valid), 32'd0);
    check_eq("rst_read", 32'(bus.fifo_read), 32'd0);
    check_eq("rst_data", bus.out_data, 32'd0);
    check_eq("rst_ch", 32'(bus.out_ch), 32'd0);
    check_eq("rst_cnt", bus.word_cnt, 32'd0);
    check_eq("rst_busy", 32'(bus.busy), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Round robin: 40 words each, burst 16, starting at ch0.
    start_phase();
    load(0, 32'h1000_0000, 40);
    load(1, 32'h2000_0000, 40);
    expect_seq(0, 32'h1000_0000, 0, 16);
    expect_seq(1, 32'h2000_0000, 0, 16);
    expect_seq(0, 32'h1000_0000, 16, 16);
    expect_seq(1, 32'h2000_0000, 16, 16);
    expect_seq(0, 32'h1000_0000, 32, 8);
    expect_seq(1, 32'h2000_0000, 32, 8);
    run(100);
    check_eq("rr_drained", 32'(exp_q.size()), 32'd0);
    check_eq("rr_switches", 32'(gaps.size()), 32'd5);
    // Burst-limit handovers cost one idle cycle; the empty handover costs two.
    for (int i = 0; i < gaps.size(); i++) begin
      check_eq("rr_gap", 32'(gaps[i]), (i < 4) ? 32'd2 : 32'd3);
    end
    check_eq("rr_cnt", bus.word_cnt, 32'd80);

    // Single channel, 5 words back to back.
    start_phase();
    load(0, 32'hA000_0000, 5);
    expect_seq(0, 32'hA000_0000, 0, 5);
    run(12);
    check_eq("single_drained", 32'(exp_q.size()), 32'd0);
    check_eq("single_pops0", 32'(pops0), 32'd5);
    check_eq("single_pops1", 32'(pops1), 32'd0);
    check_eq("single_span", 32'(last_acc - first_acc), 32'd4);
    check_eq("single_cnt", bus.word_cnt, 32'd85);
    check_eq("single_idle", 32'(bus.busy), 32'd0);

    // Back-pressure: ready toggles every cycle.
    start_phase();
    load(1, 32'hB000_0000, 6);
    expect_seq(1, 32'hB000_0000, 0, 6);
    for (int t = 0; t < 30; t++) begin
      bus.out_ready = ((t % 2) == 0);
      tick();
    end
    bus.out_ready = 1'b1;
    run(2);
    check_eq("bp_drained", 32'(exp_q.size()), 32'd0);
    check_eq("bp_pops1", 32'(pops1), 32'd6);
    check_eq("bp_cnt", bus.word_cnt, 32'd91);

    // Mask: only ch1 enabled, then disabled mid-burst.
    start_phase();
    bus.ch_enable = 2'b10;
    load(0, 32'hC000_0000, 4);
    load(1, 32'hD000_0000, 10);
    expect_seq(1, 32'hD000_0000, 0, 2);
    run(3);
    bus.ch_enable = 2'b00;
    run(5);
    check_eq("mask_drained", 32'(exp_q.size()), 32'd0);
    check_eq("mask_left0", 32'(fq0.size()), 32'd4);
    check_eq("mask_left1", 32'(fq1.size()), 32'd8);
    check_eq("mask_pops0", 32'(pops0), 32'd0);
    check_eq("mask_busy", 32'(bus.busy), 32'd0);
    check_eq("mask_cnt", bus.word_cnt, 32'd93);

    // Reset mid-burst with a held word.
    start_phase();
    fq0.delete();
    fq1.delete();
    bus.ch_enable = 2'b11;
    bus.out_ready = 1'b0;
    load(0, 32'h3000_0000, 10);
    run(4);
    check_eq("pre_rst_valid", 32'(bus.out_valid), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check_eq("arst_valid", 32'(bus.out_valid), 32'd0);
    check_eq("arst_read", 32'(bus.fifo_read), 32'd0);
    check_eq("arst_cnt", bus.word_cnt, 32'd0);
    check_eq("arst_busy", 32'(bus.busy), 32'd0);
    prev_v = 1'b0;
    @(negedge clk);
    tick();
    check_eq("rst_held_q0", 32'(fq0.size()), 32'd9);
    rst_n = 1'b1;
    start_phase();
    load(1, 32'h4000_0000, 3);
    expect_seq(0, 32'h3000_0000, 1, 9);
    expect_seq(1, 32'h4000_0000, 0, 3);
    bus.out_ready = 1'b1;
    run(25);
    check_eq("post_rst_drained", 32'(exp_q.size()), 32'd0);
    check_eq("post_rst_cnt", bus.word_cnt, 32'd12);

    // Counter wrap from a preloaded all-ones value.
    force dut.r_word_cnt = 32'hFFFF_FFFF;
    #1 release dut.r_word_cnt;
    check_eq("wrap_preload", bus.word_cnt, 32'hFFFF_FFFF);
    @(negedge clk);
    start_phase();
    load(0, 32'h5000_0000, 1);
    expect_seq(0, 32'h5000_0000, 0, 1);
    run(5);
    check_eq("wrap_drained", 32'(exp_q.size()), 32'd0);
    check_eq("wrap_cnt", bus.word_cnt, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
